vga_tile_renderer: RTL and testbench

- Parametrised VGA timing generator and tile-board renderer. Next generation of the snake display path.
- Generalises the fixed 640x400, 32x16, 1-bit board to:
  - configurable timings, sync polarities, tile size, board size and placement;
  - configurable board-memory read latency;
  - multi-bit cell values mapped through a fixed 4-entry palette.
- Sits between the game-state board RAM and the VGA pins.

---
 rtl/vga_tile_renderer.sv | 165 ++++++++++++++++
 tb/tb_vga_tile_renderer.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/vga_tile_renderer.sv
// vga_tile_renderer: VGA timing generator and tile-board renderer; define VGA_FRAME_TICK_EN to add the frame_tick output
`timescale 1ns/1ps
module vga_tile_renderer #(
    parameter int H_ACTIVE  = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_ACTIVE  = 400,
    parameter int V_FP      = 12,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 35,
    parameter int HS_POL    = 0,
    parameter int VS_POL    = 1,
    parameter int TILE_LOG2 = 4,
    parameter int BOARD_W   = 32,
    parameter int BOARD_H   = 16,
    parameter int BOARD_X0  = 64,
    parameter int BOARD_Y0  = 48,
    parameter int BORDER    = 16,
    parameter int RD_LAT    = 1,
    parameter int CELL_W    = 2
) (
    input  logic                                               clk,
    input  logic                                               rst,
    output logic                                               HS,
    output logic                                               VS,
    output logic [2:0]                                         R,
    output logic [2:0]                                         G,
    output logic [1:0]                                         B,
    output logic [(BOARD_W > 1 ? $clog2(BOARD_W) : 1)-1:0]     board_x,
    output logic [(BOARD_H > 1 ? $clog2(BOARD_H) : 1)-1:0]     board_y,
    output logic                                               board_rd,
    input  logic [CELL_W-1:0]                                  board_cell
`ifdef VGA_FRAME_TICK_EN
    ,
    output logic                                               frame_tick
`endif
);
    localparam int XW      = BOARD_W > 1 ? $clog2(BOARD_W) : 1;
    localparam int YW      = BOARD_H > 1 ? $clog2(BOARD_H) : 1;
    localparam int TS      = 1 << TILE_LOG2;
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int BX1     = BOARD_X0 + BOARD_W * TS;
    localparam int BY1     = BOARD_Y0 + BOARD_H * TS;
    localparam logic HP    = 1'(HS_POL);
    localparam logic VP    = 1'(VS_POL);
`ifdef VGA_FRAME_TICK_EN
    localparam int FW      = 7;
`else
    localparam int FW      = 6;
`endif

    generate
        if (BOARD_X0 < BORDER || BX1 + BORDER > H_ACTIVE ||
            BOARD_Y0 < BORDER || BY1 + BORDER > V_ACTIVE) begin : g_bad_place
            $error("vga_tile_renderer: board plus border must lie inside the active area");
        end
        if (RD_LAT < 0 || RD_LAT > 3 || CELL_W < 1 || CELL_W > 2) begin : g_bad_cfg
            $error("vga_tile_renderer: RD_LAT must be 0..3 and CELL_W 1..2");
        end
    endgenerate

    logic [HW-1:0] r_h;
    logic [VW-1:0] r_v;
    logic [31:0]   w_h, w_v, w_lx, w_ly;
    logic          w_inb;
    logic [FW-1:0] w_flags;
    logic [FW-1:0] r_dl [0:RD_LAT];
    logic [FW-1:0] w_last;
    logic [1:0]    w_cell;
    logic [7:0]    w_pal, w_col;

    assign w_h    = 32'(r_h);
    assign w_v    = 32'(r_v);
    assign w_lx   = (w_h - BOARD_X0) & (TS - 1);
    assign w_ly   = (w_v - BOARD_Y0) & (TS - 1);
    assign w_last = r_dl[RD_LAT];
    assign w_cell = 2'(board_cell);

    // Pixel and line counters; v advances when h wraps
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_h <= '0;
            r_v <= '0;
        end else if (r_h == HW'(H_TOTAL - 1)) begin
            r_h <= '0;
            r_v <= (r_v == VW'(V_TOTAL - 1)) ? '0 : r_v + VW'(1);
        end else begin
            r_h <= r_h + HW'(1);
        end
    end

    // Per-pixel flags: [0] visible, [1] border ring, [2] inside board, [3] in-dot, [4] HS active, [5] VS active, [6] frame tick
    always_comb begin
        w_inb      = w_h >= BOARD_X0 && w_h < BX1 && w_v >= BOARD_Y0 && w_v < BY1;
        w_flags    = '0;
        w_flags[0] = w_h < H_ACTIVE && w_v < V_ACTIVE;
        w_flags[1] = !w_inb && w_h >= BOARD_X0 - BORDER && w_h < BX1 + BORDER &&
                     w_v >= BOARD_Y0 - BORDER && w_v < BY1 + BORDER;
        w_flags[2] = w_inb;
        w_flags[3] = w_lx >= 2 && w_lx <= TS - 2 && w_ly >= 2 && w_ly <= TS - 2;
        w_flags[4] = w_h >= H_ACTIVE + H_FP && w_h < H_ACTIVE + H_FP + H_SYNC;
        w_flags[5] = w_v >= V_ACTIVE + V_FP && w_v < V_ACTIVE + V_FP + V_SYNC;
`ifdef VGA_FRAME_TICK_EN
        w_flags[FW-1] = w_h == H_ACTIVE - 1 && w_v == V_ACTIVE - 1;
`endif
    end

    // Board address stage: addresses update only inside the board and hold elsewhere
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            board_x  <= '0;
            board_y  <= '0;
            board_rd <= 1'b0;
        end else begin
            board_rd <= w_inb;
            if (w_inb) begin
                board_x <= XW'((w_h - BOARD_X0) >> TILE_LOG2);
                board_y <= YW'((w_v - BOARD_Y0) >> TILE_LOG2);
            end
        end
    end

    // Flag delay line, RD_LAT+1 deep, so the last stage lines up with board_cell
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i <= RD_LAT; i++) r_dl[i] <= '0;
        end else begin
            r_dl[0] <= w_flags;
            for (int i = 1; i <= RD_LAT; i++) r_dl[i] <= r_dl[i-1];
        end
    end

    // Colour select: blank, border, palette dot, or board background
    always_comb begin
        w_pal = w_cell == 2'd1 ? 8'hFF : w_cell == 2'd2 ? 8'hE0 : 8'h1C;
        w_col = !w_last[0] ? 8'h00 :
                w_last[1] ? 8'h4A :
                (w_last[2] && w_last[3] && w_cell != 2'd0) ? w_pal : 8'h25;
    end

    // Pin register: sync and colour leave together, RD_LAT+2 cycles after the counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            HS        <= ~HP;
            VS        <= ~VP;
            {R, G, B} <= 8'h00;
        end else begin
            HS        <= w_last[4] ? HP : ~HP;
            VS        <= w_last[5] ? VP : ~VP;
            {R, G, B} <= w_col;
        end
    end

`ifdef VGA_FRAME_TICK_EN
    // Frame tick marks the last visible pixel arriving at the pins
    always_ff @(posedge clk or posedge rst) begin
        if (rst) frame_tick <= 1'b0;
        else     frame_tick <= w_last[FW-1];
    end
`endif
endmodule

// File: tb/tb_vga_tile_renderer.sv
// tb_vga_tile_renderer: randomized board contents checked against a pixel-level reference model
`timescale 1ns/1ps
module tb_vga_tile_renderer;
    localparam int H_ACTIVE = 64, H_FP = 4, H_SYNC = 8, H_BP = 4;
    localparam int V_ACTIVE = 40, V_FP = 2, V_SYNC = 2, V_BP = 3;
    localparam int HS_POL = 0, VS_POL = 1;
    localparam int TILE_LOG2 = 3, BOARD_W = 4, BOARD_H = 3;
    localparam int BOARD_X0 = 16, BOARD_Y0 = 8, BORDER = 4;
    localparam int RD_LAT = 2, CELL_W = 2;
    localparam int HT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int VT = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int FRAME = HT * VT;
    localparam int TS = 1 << TILE_LOG2;
    localparam int L = RD_LAT + 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       HS, VS, board_rd;
    logic [2:0] R, G;
    logic [1:0] B, board_x, board_y, board_cell;
`ifdef VGA_FRAME_TICK_EN
    logic       frame_tick;
`endif
    logic [1:0] mem [0:3][0:3];
    logic [1:0] pipe [0:RD_LAT-1];
    int checks = 0, errors = 0, k = 0, exp_bx = 0, exp_by = 0;

    always #5 clk = ~clk;

    vga_tile_renderer #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .HS_POL(HS_POL), .VS_POL(VS_POL), .TILE_LOG2(TILE_LOG2),
        .BOARD_W(BOARD_W), .BOARD_H(BOARD_H), .BOARD_X0(BOARD_X0), .BOARD_Y0(BOARD_Y0),
        .BORDER(BORDER), .RD_LAT(RD_LAT), .CELL_W(CELL_W)
    ) dut (
        .clk(clk), .rst(rst), .HS(HS), .VS(VS), .R(R), .G(G), .B(B),
        .board_x(board_x), .board_y(board_y), .board_rd(board_rd), .board_cell(board_cell)
`ifdef VGA_FRAME_TICK_EN
        , .frame_tick(frame_tick)
`endif
    );

    // Board RAM with RD_LAT cycles of read latency
    always @(posedge clk) begin
        pipe[0] <= mem[board_x][board_y];
        for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign board_cell = pipe[RD_LAT-1];

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h (k=%0d)", tag, got, exp, k);
        end
    endtask

    function automatic bit in_board(int n);
        int h = n % HT;
        int v = (n / HT) % VT;
        return n >= 0 && h >= BOARD_X0 && h < BOARD_X0 + BOARD_W * TS &&
               v >= BOARD_Y0 && v < BOARD_Y0 + BOARD_H * TS;
    endfunction

    function automatic int ref_rgb(int n);
        int h = n % HT;
        int v = (n / HT) % VT;
        int lx = (h - BOARD_X0) % TS;
        int ly = (v - BOARD_Y0) % TS;
        int c;
        bit ring = h >= BOARD_X0 - BORDER && h < BOARD_X0 + BOARD_W * TS + BORDER &&
                   v >= BOARD_Y0 - BORDER && v < BOARD_Y0 + BOARD_H * TS + BORDER && !in_board(n);
        if (h >= H_ACTIVE || v >= V_ACTIVE) return 0;
        if (ring) return 'h4A;
        if (!in_board(n)) return 'h25;
        c = int'(mem[(h - BOARD_X0) / TS][(v - BOARD_Y0) / TS]);
        if (lx < 2 || lx > TS - 2 || ly < 2 || ly > TS - 2 || c == 0) return 'h25;
        return c == 1 ? 'hFF : c == 2 ? 'hE0 : 'h1C;
    endfunction

    function automatic int ref_hs(int n);
        int h = n % HT;
        return (h >= H_ACTIVE + H_FP && h < H_ACTIVE + H_FP + H_SYNC) ? HS_POL : 1 - HS_POL;
    endfunction

    function automatic int ref_vs(int n);
        int v = (n / HT) % VT;
        return (v >= V_ACTIVE + V_FP && v < V_ACTIVE + V_FP + V_SYNC) ? VS_POL : 1 - VS_POL;
    endfunction

    task automatic fill_mem();
        for (int x = 0; x < 4; x++)
            for (int y = 0; y < 4; y++)
                mem[x][y] = (x < BOARD_W && y < BOARD_H) ? 2'($urandom) : 2'd0;
        mem[0][0] = 2'd1;
        mem[BOARD_W-1][BOARD_H-1] = 2'd3;
    endtask

    task automatic check_reset(input string tag);
        chk($sformatf("%s_rgb", tag), {R, G, B}, 0);
        chk($sformatf("%s_hs", tag), HS, 1 - HS_POL);
        chk($sformatf("%s_vs", tag), VS, 1 - VS_POL);
        chk($sformatf("%s_rd", tag), board_rd, 0);
        chk($sformatf("%s_bx", tag), board_x, 0);
        chk($sformatf("%s_by", tag), board_y, 0);
`ifdef VGA_FRAME_TICK_EN
        chk($sformatf("%s_tick", tag), frame_tick, 0);
`endif
    endtask

    // One clock: board stage reflects pixel k-1, pins reflect pixel k-L
    task automatic step();
        int n;
        @(posedge clk);
        k++;
        n = k - 1;
        if (in_board(n)) begin
            exp_bx = (n % HT - BOARD_X0) / TS;
            exp_by = ((n / HT) % VT - BOARD_Y0) / TS;
        end
        @(negedge clk);
        chk("board_rd", board_rd, int'(in_board(n)));
        chk("board_x", board_x, exp_bx);
        chk("board_y", board_y, exp_by);
        n = k - L;
        chk("rgb", {R, G, B}, n < 0 ? 0 : ref_rgb(n));
        chk("hs", HS, n < 0 ? 1 - HS_POL : ref_hs(n));
        chk("vs", VS, n < 0 ? 1 - VS_POL : ref_vs(n));
`ifdef VGA_FRAME_TICK_EN
        chk("tick", frame_tick, int'(n >= 0 && n % FRAME == (V_ACTIVE - 1) * HT + H_ACTIVE - 1));
`endif
    endtask

    initial begin
        int budget;
        fill_mem();
        repeat (3) @(negedge clk);
        check_reset("init");
        rst = 1'b0;
        k = 0; exp_bx = 0; exp_by = 0;
        repeat (2 * FRAME + 10) step();
        repeat ($urandom_range(0, 40)) step();
        budget = FRAME;
        while (!(in_board(k - L) && in_board(k - 1)) && budget > 0) begin
            step();
            budget--;
        end
        chk("find_board", int'(budget > 0), 1);
        #2 rst = 1'b1;
        #1 check_reset("async");
        fill_mem();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset("held");
        rst = 1'b0;
        k = 0; exp_bx = 0; exp_by = 0;
        repeat (FRAME + 50) step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
